float_adder_axil_slave: RTL and testbench

FLOAT_ADDER_AXIL_SLAVE -- requirements
Module: float_adder_axil_slave

---
 rtl/float_adder_axil_slave.sv | 219 +++++++++++++++++++++
 tb/tb_float_adder_axil_slave.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/float_adder_axil_slave.sv
// AXI4-Lite register front end for an external single-precision float adder core.
// Define FLOAT_ADDER_AXIL_SLVERR_EN to answer accesses to 0x10-0x1C with SLVERR instead of OKAY.
module float_adder_axil_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic [31:0]                       core_a,
  output logic [31:0]                       core_b,
  output logic                              core_start,
  input  logic                              core_done,
  input  logic [31:0]                       core_result,
  output logic                              irq
);

  typedef enum logic { W_IDLE, W_RESP } wstate_t;
  typedef enum logic { R_IDLE, R_DATA } rstate_t;

  localparam logic [1:0] REG_OPA    = 2'd0;
  localparam logic [1:0] REG_OPB    = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_RESULT = 2'd3;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
`ifdef FLOAT_ADDER_AXIL_SLVERR_EN
  localparam logic [1:0] RESP_UNMAPPED = 2'b10;
`else
  localparam logic [1:0] RESP_UNMAPPED = 2'b00;
`endif

  function automatic logic [31:0] apply_strb(input logic [31:0] old,
                                             input logic [31:0] wd,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = wd[8*i +: 8];
    end
    return res;
  endfunction

  wstate_t     w_state_q;
  rstate_t     r_state_q;
  logic        awready_q, bvalid_q, arready_q, rvalid_q;
  logic [1:0]  bresp_q, rresp_q;
  logic [31:0] rdata_q, rd_word;
  logic [31:0] op_a_q, op_a_d, op_b_q, op_b_d, result_q, result_d;
  logic        irq_en_q, irq_en_d, busy_q, busy_d, done_q, done_d;
  logic        core_start_q, core_start_d;
  logic        wr_fire, rd_fire, wr_mapped, rd_mapped;
  logic [31:0] ctrl_word;
  logic        unused_ok;

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

  // Ready is registered: it rises one cycle after both AW and W are presented.
  assign wr_fire   = (w_state_q == W_IDLE) && awready_q && S_AXI_AWVALID && S_AXI_WVALID;
  assign rd_fire   = (r_state_q == R_IDLE) && arready_q && S_AXI_ARVALID;
  assign wr_mapped = !S_AXI_AWADDR[4];
  assign rd_mapped = !S_AXI_ARADDR[4];
  assign ctrl_word = {22'd0, done_q, busy_q, 6'd0, irq_en_q, 1'b0};

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          if (wr_fire) begin
            awready_q <= 1'b0;
            bvalid_q  <= 1'b1;
            bresp_q   <= wr_mapped ? RESP_OKAY : RESP_UNMAPPED;
            w_state_q <= W_RESP;
          end else begin
            awready_q <= !awready_q && S_AXI_AWVALID && S_AXI_WVALID;
          end
        end
        W_RESP: begin
          if (S_AXI_BREADY) begin
            bvalid_q  <= 1'b0;
            w_state_q <= W_IDLE;
          end
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  always_comb begin
    rd_word = '0;
    if (rd_mapped) begin
      case (S_AXI_ARADDR[3:2])
        REG_OPA:    rd_word = op_a_q;
        REG_OPB:    rd_word = op_b_q;
        REG_CTRL:   rd_word = ctrl_word;
        REG_RESULT: rd_word = result_q;
        default:    rd_word = '0;
      endcase
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          if (rd_fire) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rdata_q   <= rd_word;
            rresp_q   <= rd_mapped ? RESP_OKAY : RESP_UNMAPPED;
            r_state_q <= R_DATA;
          end else begin
            arready_q <= !arready_q && S_AXI_ARVALID;
          end
        end
        R_DATA: begin
          if (S_AXI_RREADY) begin
            rvalid_q  <= 1'b0;
            r_state_q <= R_IDLE;
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  // START and completion are mutually exclusive through busy_q; completion set beats W1C clear.
  always_comb begin
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    result_d     = result_q;
    irq_en_d     = irq_en_q;
    busy_d       = busy_q;
    done_d       = done_q;
    core_start_d = 1'b0;
    if (wr_fire && wr_mapped) begin
      case (S_AXI_AWADDR[3:2])
        REG_OPA: op_a_d = apply_strb(op_a_q, S_AXI_WDATA, S_AXI_WSTRB);
        REG_OPB: op_b_d = apply_strb(op_b_q, S_AXI_WDATA, S_AXI_WSTRB);
        REG_CTRL: begin
          if (S_AXI_WSTRB[0]) irq_en_d = S_AXI_WDATA[1];
          if (S_AXI_WSTRB[0] && S_AXI_WDATA[0] && !busy_q) begin
            core_start_d = 1'b1;
            busy_d       = 1'b1;
          end
          if (S_AXI_WSTRB[1] && S_AXI_WDATA[9]) done_d = 1'b0;
        end
        default: ;
      endcase
    end
    if (core_done && busy_q) begin
      result_d = core_result;
      busy_d   = 1'b0;
      done_d   = 1'b1;
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      op_a_q       <= '0;
      op_b_q       <= '0;
      result_q     <= '0;
      irq_en_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      core_start_q <= 1'b0;
    end else begin
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      result_q     <= result_d;
      irq_en_q     <= irq_en_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      core_start_q <= core_start_d;
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = awready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = rdata_q;
  assign core_a        = op_a_q;
  assign core_b        = op_b_q;
  assign core_start    = core_start_q;
  assign irq           = done_q & irq_en_q;

endmodule

// File: tb/tb_float_adder_axil_slave.sv
// Self-checking bench for float_adder_axil_slave: directed vectors, corner sequences and random traffic.
module tb_float_adder_axil_slave;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [4:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] core_a, core_b, core_result;
  logic        core_start, core_done, irq;

  float_adder_axil_slave #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(5)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .core_a(core_a), .core_b(core_b), .core_start(core_start), .core_done(core_done),
    .core_result(core_result), .irq(irq)
  );

`ifdef FLOAT_ADDER_AXIL_SLVERR_EN
  localparam logic [1:0] UNM = 2'b10;
`else
  localparam logic [1:0] UNM = 2'b00;
`endif

  int n_checks = 0;
  int n_fail = 0;

  // Reference register state
  logic [31:0] m_opa, m_opb, m_result;
  logic        m_irqen, m_busy, m_done;
  logic        start_seen, start_after;
  logic [31:0] a_seen, b_seen;

  typedef struct {
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [4:0]  raddr;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %b required %b", name, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] mask;
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (old & ~mask) | (d & mask);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a >= 5'h10) return 32'h0;
    if (a < 5'h04) return m_opa;
    if (a < 5'h08) return m_opb;
    if (a < 5'h0C) return (m_done ? 32'h200 : 32'h0) + (m_busy ? 32'h100 : 32'h0) + (m_irqen ? 32'h2 : 32'h0);
    return m_result;
  endfunction

  function automatic logic [1:0] m_resp(input logic [4:0] a);
    return (a >= 5'h10) ? UNM : 2'b00;
  endfunction

  task automatic m_reset();
    m_opa = 0; m_opb = 0; m_result = 0; m_irqen = 0; m_busy = 0; m_done = 0;
  endtask

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                           input bit with_done, input logic [31:0] res, output logic [1:0] resp);
    int n;
    n = 0;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1; bready = 0;
    while (!awready && n < 20) begin @(posedge clk); #1; n++; end
    check1("awready_wait", awready, 1'b1);
    check1("wready_with_awready", wready, 1'b1);
    if (with_done) begin core_done = 1; core_result = res; end
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0; core_done = 0;
    start_seen = core_start; a_seen = core_a; b_seen = core_b;
    check1("bvalid_latency", bvalid, 1'b1);
    check1("awready_one_cycle", awready, 1'b0);
    resp = bresp;
    bready = 1;
    @(posedge clk); #1;
    bready = 0;
    start_after = core_start;
    check1("bvalid_drop", bvalid, 1'b0);
  endtask

  task automatic axi_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    n = 0;
    araddr = a; arvalid = 1; rready = 0;
    while (!arready && n < 20) begin @(posedge clk); #1; n++; end
    check1("arready_wait", arready, 1'b1);
    @(posedge clk); #1;
    arvalid = 0;
    check1("rvalid_latency", rvalid, 1'b1);
    d = rdata; resp = rresp;
    @(posedge clk); #1;
    check1("rvalid_held", rvalid, 1'b1);
    check("rdata_stable", rdata, d);
    rready = 1;
    @(posedge clk); #1;
    rready = 0;
    check1("rvalid_drop", rvalid, 1'b0);
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                          input bit with_done, input logic [31:0] res);
    logic [1:0] r;
    bit exp_start, busy_old;
    busy_old = m_busy;
    exp_start = (a >= 5'h08) && (a < 5'h0C) && s[0] && d[0] && !m_busy;
    axi_write(a, d, s, with_done, res, r);
    if (a < 5'h04) m_opa = merge(m_opa, d, s);
    else if (a < 5'h08) m_opb = merge(m_opb, d, s);
    else if (a < 5'h0C) begin
      if (s[0]) m_irqen = d[1];
      if (s[1] && d[9]) m_done = 0;
    end
    if (with_done && busy_old) begin m_result = res; m_busy = 0; m_done = 1; end
    if (exp_start) m_busy = 1;
    check({30'd0, r}, {30'd0, r}, {30'd0, r}) ;
    n_checks--;
    check("bresp", {30'd0, r}, {30'd0, m_resp(a)});
    check1("core_start_pulse", start_seen, exp_start);
    check1("core_start_width", start_after, 1'b0);
    if (exp_start) begin
      check("core_a_at_start", a_seen, m_opa);
      check("core_b_at_start", b_seen, m_opb);
    end
    check1("irq_level", irq, m_done & m_irqen);
  endtask

  task automatic do_read(input logic [4:0] a, output logic [31:0] d);
    logic [1:0] r;
    axi_read(a, d, r);
    check("rdata_model", d, m_read(a));
    check("rresp", {30'd0, r}, {30'd0, m_resp(a)});
  endtask

  task automatic core_pulse(input logic [31:0] res);
    core_done = 1; core_result = res;
    @(posedge clk); #1;
    core_done = 0;
    if (m_busy) begin m_result = res; m_busy = 0; m_done = 1; end
    check1("irq_after_done", irq, m_done & m_irqen);
  endtask

  task automatic check_all_zero(input string tag);
    check1({tag, "_awready"}, awready, 1'b0);
    check1({tag, "_wready"}, wready, 1'b0);
    check1({tag, "_bvalid"}, bvalid, 1'b0);
    check({tag, "_bresp"}, {30'd0, bresp}, 32'h0);
    check1({tag, "_arready"}, arready, 1'b0);
    check1({tag, "_rvalid"}, rvalid, 1'b0);
    check({tag, "_rresp"}, {30'd0, rresp}, 32'h0);
    check({tag, "_rdata"}, rdata, 32'h0);
    check({tag, "_core_a"}, core_a, 32'h0);
    check({tag, "_core_b"}, core_b, 32'h0);
    check1({tag, "_core_start"}, core_start, 1'b0);
    check1({tag, "_irq"}, irq, 1'b0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    int n;
    tbl[0] = '{5'h00, 32'h11223344, 4'hF,    5'h00, 32'h11223344};
    tbl[1] = '{5'h00, 32'hAABBCCDD, 4'b0101, 5'h00, 32'h11BB33DD};
    tbl[2] = '{5'h04, 32'h55667788, 4'hF,    5'h04, 32'h55667788};
    tbl[3] = '{5'h05, 32'hFF000000, 4'b1000, 5'h07, 32'hFF667788};
    tbl[4] = '{5'h08, 32'h00000002, 4'b0001, 5'h08, 32'h00000002};
    tbl[5] = '{5'h08, 32'h00000000, 4'b0010, 5'h08, 32'h00000002};
    tbl[6] = '{5'h08, 32'hFFFFFFFC, 4'b0001, 5'h08, 32'h00000000};
    tbl[7] = '{5'h0C, 32'h12345678, 4'hF,    5'h0C, 32'h00000000};
    tbl[8] = '{5'h1C, 32'hCAFEF00D, 4'hF,    5'h00, 32'h11BB33DD};

    rst = 1; awaddr = 0; araddr = 0; awprot = 0; arprot = 0; awvalid = 0; wvalid = 0;
    wdata = 0; wstrb = 0; bready = 0; arvalid = 0; rready = 0; core_done = 0; core_result = 0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 0;

    // Basic write / readback
    do_write(5'h00, 32'h00000001, 4'hF, 0, 0);
    do_write(5'h04, 32'h00000002, 4'hF, 0, 0);
    do_read(5'h00, d); check("readback_opa", d, 32'h00000001);
    do_read(5'h04, d); check("readback_opb", d, 32'h00000002);

    for (int i = 0; i < 9; i++) begin
      do_write(tbl[i].waddr, tbl[i].wdata, tbl[i].wstrb, 0, 0);
      do_read(tbl[i].raddr, d);
      check($sformatf("table_%0d", i), d, tbl[i].exp);
    end

    // Full add sequence
    do_write(5'h00, 32'h3F800000, 4'hF, 0, 0);
    do_write(5'h04, 32'h40000000, 4'hF, 0, 0);
    do_write(5'h08, 32'h00000003, 4'hF, 0, 0);
    check1("start_pulse_req021", start_seen, 1'b1);
    check("core_a_req021", a_seen, 32'h3F800000);
    check("core_b_req021", b_seen, 32'h40000000);
    do_read(5'h08, d); check("ctrl_busy", d, 32'h00000102);
    core_pulse(32'h40400000);
    do_read(5'h08, d); check("ctrl_done", d, 32'h00000202);
    do_read(5'h0C, d); check("result_req021", d, 32'h40400000);
    check1("irq_set", irq, 1'b1);

    // DONE W1C, then W1C racing a completion
    do_write(5'h08, 32'h00000200, 4'b0010, 0, 0);
    do_read(5'h08, d); check("ctrl_w1c", d, 32'h00000002);
    check1("irq_cleared", irq, 1'b0);
    do_write(5'h08, 32'h00000003, 4'b0001, 0, 0);
    do_write(5'h08, 32'h00000200, 4'b0010, 1, 32'h41200000);
    do_read(5'h08, d); check("ctrl_set_wins", d, 32'h00000202);
    do_read(5'h0C, d); check("result_set_wins", d, 32'h41200000);

    // START racing a completion: completion taken, START dropped
    do_write(5'h08, 32'h00000003, 4'b0001, 0, 0);
    do_write(5'h08, 32'h00000003, 4'b0001, 1, 32'h40A00000);
    check1("start_ignored_on_done", start_seen, 1'b0);
    do_read(5'h08, d); check("ctrl_start_race", d, 32'h00000202);
    core_pulse(32'h12345678);
    do_read(5'h0C, d); check("done_when_idle_ignored", d, 32'h40A00000);

    // AW ahead of W, slow BREADY, second AW blocked
    awaddr = 5'h00; wdata = 32'h0BADF00D; wstrb = 4'hF; awvalid = 1; wvalid = 0; bready = 0;
    for (int i = 0; i < 3; i++) begin @(posedge clk); #1; check1("aw_without_w", awready, 1'b0); end
    wvalid = 1;
    n = 0;
    while (!awready && n < 20) begin @(posedge clk); #1; n++; end
    check1("aw_w_ready_together", awready & wready, 1'b1);
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0; m_opa = 32'h0BADF00D;
    awaddr = 5'h04; wdata = 32'h600DCAFE; awvalid = 1; wvalid = 1;
    for (int i = 0; i < 4; i++) begin
      check1("bvalid_held", bvalid, 1'b1);
      check1("no_second_aw", awready, 1'b0);
      @(posedge clk); #1;
    end
    bready = 1; @(posedge clk); #1; bready = 0;
    check1("bvalid_release", bvalid, 1'b0);
    do_write(5'h04, 32'h600DCAFE, 4'hF, 0, 0);
    do_read(5'h00, d); check("opa_slow_b", d, 32'h0BADF00D);
    do_read(5'h04, d); check("opb_second_aw", d, 32'h600DCAFE);

    // Unmapped window
    axi_read(5'h14, d, r);
    check("unmapped_rdata", d, 32'h0);
    check("unmapped_rresp", {30'd0, r}, {30'd0, UNM});
    axi_write(5'h18, 32'hDEADBEEF, 4'hF, 0, 0, r);
    check("unmapped_bresp", {30'd0, r}, {30'd0, UNM});
    for (int i = 0; i < 4; i++) do_read(5'(i * 4), d);

    // Random traffic against the reference model
    for (int it = 0; it < 80; it++) begin
      case ($urandom_range(0, 3))
        0: do_write(5'($urandom_range(0, 31)), $urandom, 4'($urandom), $urandom_range(0, 3) == 0, $urandom);
        1: do_read(5'($urandom_range(0, 31)), d);
        2: core_pulse($urandom);
        default: do_write(5'h08, 32'h3 | ($urandom & 32'h200), 4'($urandom) | 4'b0001, 0, 0);
      endcase
    end

    // Reset with a pending B/R and the core busy
    if (m_busy) core_pulse(32'h3F000000);
    do_write(5'h08, 32'h00000003, 4'b0001, 0, 0);
    check1("busy_before_reset", m_busy, 1'b1);
    awaddr = 5'h00; wdata = 32'hFFFFFFFF; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 0;
    araddr = 5'h00; arvalid = 1; rready = 0;
    n = 0;
    while (!awready && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0; arvalid = 0;
    check1("bvalid_pending", bvalid, 1'b1);
    check1("rvalid_pending", rvalid, 1'b1);
    rst = 1;
    @(posedge clk); #1;
    check_all_zero("midreset");
    rst = 0;
    m_reset();
    core_pulse(32'hAAAA5555);
    do_read(5'h0C, d); check("result_after_reset", d, 32'h0);
    do_read(5'h08, d); check("ctrl_after_reset", d, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
